// File: rtl/inst_rom_loader_pkg.sv
// Shared widths, defaults and FSM encoding for the instruction ROM loader.
package inst_rom_loader_pkg;

    localparam int unsigned ROM_DEPTH   = 16;
    localparam int unsigned ROM_AW      = 4;
    localparam int unsigned ROM_DW      = 8;
    localparam int unsigned LD_HOLD_CYC = 2;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ERR   = 3'd4
    } ld_state_e;

    // Checksum byte is the one's complement of the mod-256 image sum.
    function automatic logic csum_ok(input logic [ROM_DW-1:0] sum,
                                     input logic [ROM_DW-1:0] csum);
        return csum == (sum ^ 8'hFF);
    endfunction

endpackage

// File: rtl/inst_rom_loader_if.sv
// Byte-stream loader port: host drives bytes, loader returns ready and status.
interface inst_rom_loader_if;
    import inst_rom_loader_pkg::*;

    logic              ld_start;
    logic              ld_valid;
    logic [ROM_DW-1:0] ld_data;
    logic              ld_ready;
    logic              load_done;
    logic              load_err;

    modport master (output ld_start, ld_valid, ld_data,
                    input  ld_ready, load_done, load_err);
    modport slave  (input  ld_start, ld_valid, ld_data,
                    output ld_ready, load_done, load_err);
endinterface

// File: rtl/inst_rom_store.sv
// Instruction word array: async clear, synchronous write, combinational read.
module inst_rom_store
    import inst_rom_loader_pkg::*;
#(
    parameter int unsigned DEPTH = ROM_DEPTH,
    parameter int unsigned AW    = ROM_AW
) (
    input  logic              clk_cpu,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [ROM_DW-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [ROM_DW-1:0] rdata
);

    logic [ROM_DW-1:0] mem [DEPTH];

    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Program memory for the 4-bit CPU with a checksummed run-time byte loader
// that holds the CPU in reset while a new image is written.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int unsigned DEPTH    = ROM_DEPTH,
    parameter int unsigned HOLD_CYC = LD_HOLD_CYC
) (
    input  logic                     clk_cpu,
    input  logic                     reset,
    input  logic [$clog2(DEPTH)-1:0] pc,
    output logic [ROM_DW-1:0]        inst,
    output logic                     cpu_rst,
    inst_rom_loader_if.slave         ld
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    ld_state_e         state_q;
    logic [AW-1:0]     wp_q;
    logic [ROM_DW-1:0] sum_q;
    logic [HW-1:0]     hold_q;
    logic              ready_q;
    logic              done_q;
    logic              err_q;
    logic [ROM_DW-1:0] rd_data;
    logic              accept_c;
    logic              wr_en_c;

    // A start request wins over any byte offered in the same cycle.
    assign accept_c = ld.ld_valid & ready_q & ~ld.ld_start;
    assign wr_en_c  = accept_c & (state_q == ST_LOAD);

    inst_rom_store #(.DEPTH(DEPTH), .AW(AW)) u_store (
        .clk_cpu (clk_cpu),
        .reset   (reset),
        .we      (wr_en_c),
        .waddr   (wp_q),
        .wdata   (ld.ld_data),
        .raddr   (pc),
        .rdata   (rd_data)
    );

    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            wp_q    <= '0;
            sum_q   <= '0;
            hold_q  <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cpu_rst <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ld.ld_start) begin
                state_q <= ST_LOAD;
                wp_q    <= '0;
                sum_q   <= '0;
                ready_q <= 1'b1;
                cpu_rst <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_RUN: ;
                    ST_LOAD: begin
                        if (accept_c) begin
                            wp_q  <= wp_q + AW'(1);
                            sum_q <= sum_q + ld.ld_data;
                            if (wp_q == AW'(DEPTH - 1)) state_q <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (accept_c) begin
                            ready_q <= 1'b0;
                            hold_q  <= '0;
                            if (csum_ok(sum_q, ld.ld_data)) begin
                                state_q <= ST_HOLD;
                                err_q   <= 1'b0;
                            end else begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (hold_q == HW'(HOLD_CYC - 1)) begin
                            state_q <= ST_RUN;
                            cpu_rst <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            hold_q <= hold_q + HW'(1);
                        end
                    end
                    ST_ERR: ;
                    default: begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b0;
                        cpu_rst <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The CPU only sees real instructions while running.
    assign inst         = (state_q == ST_RUN) ? rd_data : '0;
    assign ld.ld_ready  = ready_q;
    assign ld.load_done = done_q;
    assign ld.load_err  = err_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: reset, good/bad loads, stalls, restart, mid-load reset.
module tb_inst_rom_loader;

    logic       clk_cpu = 1'b0;
    logic       reset;
    logic [3:0] pc;
    logic [7:0] inst;
    logic       cpu_rst;
    int         errors = 0;
    int         checks = 0;
    int         rdy;

    inst_rom_loader_if ldif ();

    inst_rom_loader dut (
        .clk_cpu (clk_cpu),
        .reset   (reset),
        .pc      (pc),
        .inst    (inst),
        .cpu_rst (cpu_rst),
        .ld      (ldif)
    );

    always #5 clk_cpu = ~clk_cpu;

    task automatic tick();
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input string tag, input logic [7:0] base, input bit zero);
        for (int i = 0; i < 16; i++) begin
            pc = 4'(i);
            tick();
            chk(tag, inst, zero ? 8'h00 : base + 8'(i));
        end
    endtask

    task automatic load_image(input logic [7:0] base, input logic [7:0] csum,
                              input bit gaps, output int rdy_cycles);
        rdy_cycles = 0;
        ldif.ld_start = 1'b1;
        tick();
        ldif.ld_start = 1'b0;
        chk("start_cpu_rst", 8'(cpu_rst), 8'h01);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                ldif.ld_valid = 1'b0;
                repeat (i % 4) begin
                    tick();
                    chk("gap_ready", 8'(ldif.ld_ready), 8'h01);
                end
            end
            ldif.ld_valid = 1'b1;
            ldif.ld_data  = base + 8'(i);
            if (ldif.ld_ready) rdy_cycles++;
            tick();
        end
        ldif.ld_data = csum;
        if (ldif.ld_ready) rdy_cycles++;
        tick();
        ldif.ld_valid = 1'b0;
        ldif.ld_data  = 8'h00;
    endtask

    task automatic finish_good(input string tag);
        chk({tag, "_err_clr"}, 8'(ldif.load_err), 8'h00);
        chk({tag, "_hold_rdy"}, 8'(ldif.ld_ready), 8'h00);
        chk({tag, "_hold1_rst"}, 8'(cpu_rst), 8'h01);
        chk({tag, "_hold1_done"}, 8'(ldif.load_done), 8'h00);
        tick();
        chk({tag, "_hold2_rst"}, 8'(cpu_rst), 8'h01);
        tick();
        chk({tag, "_run_rst"}, 8'(cpu_rst), 8'h00);
        chk({tag, "_done"}, 8'(ldif.load_done), 8'h01);
        tick();
        chk({tag, "_done_pulse"}, 8'(ldif.load_done), 8'h00);
    endtask

    initial begin
        reset         = 1'b0;
        pc            = 4'h0;
        ldif.ld_start = 1'b0;
        ldif.ld_valid = 1'b0;
        ldif.ld_data  = 8'h00;

        // Reset state
        repeat (3) tick();
        chk("rst_cpu_rst", 8'(cpu_rst), 8'h00);
        chk("rst_ready", 8'(ldif.ld_ready), 8'h00);
        chk("rst_done", 8'(ldif.load_done), 8'h00);
        chk("rst_err", 8'(ldif.load_err), 8'h00);
        check_mem("rst_mem", 8'h00, 1'b1);
        reset = 1'b1;
        tick();

        // Good load 30..3F, checksum 87
        load_image(8'h30, 8'h87, 1'b0, rdy);
        chk("good_ready_cycles", 8'(rdy), 8'd17);
        finish_good("good");
        pc = 4'h5;
        #1;
        chk("good_pc5", inst, 8'h35);
        check_mem("good_mem", 8'h30, 1'b0);

        // Bad checksum lands in ERR with CPU held
        load_image(8'h40, 8'h00, 1'b0, rdy);
        chk("bad_err", 8'(ldif.load_err), 8'h01);
        chk("bad_cpu_rst", 8'(cpu_rst), 8'h01);
        chk("bad_ready", 8'(ldif.ld_ready), 8'h00);
        pc = 4'h5;
        repeat (3) tick();
        chk("bad_err_stay", 8'(ldif.load_err), 8'h01);
        chk("bad_rst_stay", 8'(cpu_rst), 8'h01);
        chk("bad_inst", inst, 8'h00);

        // Good load after ERR clears the flag
        load_image(8'h50, 8'h87, 1'b0, rdy);
        finish_good("recov");
        check_mem("recov_mem", 8'h50, 1'b0);

        // Stalled stream with 0..3 cycle gaps
        load_image(8'h60, 8'h87, 1'b1, rdy);
        finish_good("stall");
        check_mem("stall_mem", 8'h60, 1'b0);

        // Restart after 7 bytes; byte offered with the start is dropped
        ldif.ld_start = 1'b1;
        tick();
        ldif.ld_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ldif.ld_valid = 1'b1;
            ldif.ld_data  = 8'h70 + 8'(i);
            tick();
        end
        ldif.ld_data = 8'hEE;
        load_image(8'hB0, 8'h87, 1'b0, rdy);
        chk("restart_ready_cycles", 8'(rdy), 8'd17);
        finish_good("restart");
        check_mem("restart_mem", 8'hB0, 1'b0);

        // Reset in the middle of a load
        ldif.ld_start = 1'b1;
        tick();
        ldif.ld_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ldif.ld_valid = 1'b1;
            ldif.ld_data  = 8'hC0 + 8'(i);
            tick();
        end
        ldif.ld_valid = 1'b0;
        chk("midrst_pre_rst", 8'(cpu_rst), 8'h01);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_cpu_rst", 8'(cpu_rst), 8'h00);
        chk("midrst_ready", 8'(ldif.ld_ready), 8'h00);
        check_mem("midrst_mem", 8'h00, 1'b1);
        reset = 1'b1;
        tick();
        load_image(8'hD0, 8'h87, 1'b0, rdy);
        finish_good("post");
        check_mem("post_mem", 8'hD0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
